// File: rtl/park_pkg.sv
// Shared encodings for the parking gate/occupancy block: FSM states, seven-segment
// digit patterns (active-low {g,f,e,d,c,b,a}) and the display-limited slot count.
package park_pkg;

  localparam int unsigned MAX_SLOTS = 9;

  // 2'd3 is unused and recovers to StIdle with the gate closed.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOpen = 2'd1,
    StPass = 2'd2
  } park_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/park_seg_decoder.sv
// Combinational 4-bit digit to active-low seven-segment pattern; values above 9 blank
// the display.
module park_seg_decoder
  import park_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/park_gate_occupancy.sv
// Parking gate controller with slot occupancy and free-slot display.
// Define PARK_TIMEOUT_ALARM_EN to latch an alarm when an opened gate times out unused.
module park_gate_occupancy
  import park_pkg::*;
#(
  parameter int unsigned SLOTS       = 9,
  parameter int unsigned OPEN_TICKS  = 50,
  parameter int unsigned CLOSE_TICKS = 10
) (
  input  logic       reset,
  input  logic       clk_5hz,
  input  logic       gate_req,
  input  logic       entry_pulse,
  input  logic       exit_pulse,
  output logic       gate_open,
  output logic       full,
  output logic       denied,
  output logic       alarm,
  output logic [3:0] free_slots,
  output logic [6:0] seg7
);

  if (SLOTS < 1 || SLOTS > MAX_SLOTS) begin : gen_bad_slots
    $error("SLOTS must be within 1..MAX_SLOTS");
  end

  localparam logic [3:0] SlotsW     = 4'(SLOTS);
  localparam logic [7:0] OpenLastW  = 8'(OPEN_TICKS - 1);
  localparam logic [7:0] CloseLastW = 8'(CLOSE_TICKS - 1);

  park_state_e state_q;
  logic [7:0]  timer_q;
  logic        req_q;
  logic        gate_open_q;
  logic        denied_q;
  logic [3:0]  occ_q, occ_d;
  logic        req_rise, timeout, inc, dec;

  assign req_rise = gate_req & ~req_q;
  assign timeout  = (state_q == StOpen) && !entry_pulse && (timer_q == OpenLastW);
  // One car per authorisation: only an entry seen while OPEN counts.
  assign inc      = (state_q == StOpen) && entry_pulse && (occ_q < SlotsW);
  assign dec      = exit_pulse && (occ_q != 4'd0);

  always_comb begin
    occ_d = occ_q;
    if (inc && !dec) begin
      occ_d = occ_q + 4'd1;
    end else if (dec && !inc) begin
      occ_d = occ_q - 4'd1;
    end
  end

  always_ff @(posedge clk_5hz or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      timer_q     <= 8'd0;
      req_q       <= 1'b0;
      gate_open_q <= 1'b0;
      denied_q    <= 1'b0;
      occ_q       <= 4'd0;
    end else begin
      req_q    <= gate_req;
      occ_q    <= occ_d;
      denied_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_rise && !full) begin
            state_q     <= StOpen;
            timer_q     <= 8'd0;
            gate_open_q <= 1'b1;
          end else if (req_rise) begin
            denied_q <= 1'b1;
          end
        end
        StOpen: begin
          if (entry_pulse) begin
            state_q <= StPass;
            timer_q <= 8'd0;
          end else if (timeout) begin
            state_q     <= StIdle;
            gate_open_q <= 1'b0;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        StPass: begin
          if (timer_q == CloseLastW) begin
            state_q     <= StIdle;
            gate_open_q <= 1'b0;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: begin
          state_q     <= StIdle;
          timer_q     <= 8'd0;
          gate_open_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARK_TIMEOUT_ALARM_EN
  logic alarm_q;

  // Cleared only by an accepted request; a denied one leaves it standing.
  always_ff @(posedge clk_5hz or posedge reset) begin
    if (reset) begin
      alarm_q <= 1'b0;
    end else if (state_q == StIdle && req_rise && !full) begin
      alarm_q <= 1'b0;
    end else if (timeout) begin
      alarm_q <= 1'b1;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

  assign gate_open  = gate_open_q;
  assign denied     = denied_q;
  assign full       = (occ_q == SlotsW);
  assign free_slots = SlotsW - occ_q;

  park_seg_decoder u_seg_decoder (
    .digit (free_slots),
    .seg   (seg7)
  );

endmodule

// File: tb/tb_park_gate_occupancy.sv
// Directed bench for park_gate_occupancy; inputs change and outputs are sampled just
// after the falling edge of clk_5hz.
module tb_park_gate_occupancy;

  localparam int unsigned SLOTS       = 9;
  localparam int unsigned OPEN_TICKS  = 50;
  localparam int unsigned CLOSE_TICKS = 10;

`ifdef PARK_TIMEOUT_ALARM_EN
  localparam logic ALARM_EXP = 1'b1;
`else
  localparam logic ALARM_EXP = 1'b0;
`endif

  logic       reset = 1'b1;
  logic       clk_5hz = 1'b0;
  logic       gate_req = 1'b0;
  logic       entry_pulse = 1'b0;
  logic       exit_pulse = 1'b0;
  logic       gate_open, full, denied, alarm;
  logic [3:0] free_slots;
  logic [6:0] seg7;

  int checks = 0;
  int errors = 0;

  always #10 clk_5hz = ~clk_5hz;

  park_gate_occupancy #(
    .SLOTS       (SLOTS),
    .OPEN_TICKS  (OPEN_TICKS),
    .CLOSE_TICKS (CLOSE_TICKS)
  ) dut (
    .reset       (reset),
    .clk_5hz     (clk_5hz),
    .gate_req    (gate_req),
    .entry_pulse (entry_pulse),
    .exit_pulse  (exit_pulse),
    .gate_open   (gate_open),
    .full        (full),
    .denied      (denied),
    .alarm       (alarm),
    .free_slots  (free_slots),
    .seg7        (seg7)
  );

  task automatic step();
    @(negedge clk_5hz);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Stimulus only: one authorised car enters, then wait until the gate has closed.
  task automatic admit_car();
    gate_req = 1'b1;
    step();
    gate_req = 1'b0;
    entry_pulse = 1'b1;
    step();
    entry_pulse = 1'b0;
    repeat (CLOSE_TICKS) step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (gate_open !== 1'b0) begin
      errors++; $display("FAIL reset_gate_open got %b want 0", gate_open);
    end
    checks++;
    if (free_slots !== 4'd9) begin
      errors++; $display("FAIL reset_free_slots got %0d want 9", free_slots);
    end
    checks++;
    if (full !== 1'b0 || denied !== 1'b0 || alarm !== 1'b0) begin
      errors++; $display("FAIL reset_flags got full=%b denied=%b alarm=%b want 000",
                         full, denied, alarm);
    end
    checks++;
    if (seg7 !== 7'b0010000) begin
      errors++; $display("FAIL reset_seg7 got %b want 0010000", seg7);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    gate_req = 1'b1;
    for (int i = 1; i <= int'(OPEN_TICKS); i++) begin
      step();
      if (gate_open !== 1'b1 && bad == 0) bad = i;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL timeout_open_window gate_open low at cycle %0d want high", bad);
    end
    step();
    checks++;
    if (gate_open !== 1'b0) begin
      errors++; $display("FAIL timeout_close got %b want 0", gate_open);
    end
    checks++;
    if (alarm !== ALARM_EXP) begin
      errors++; $display("FAIL timeout_alarm got %b want %b", alarm, ALARM_EXP);
    end
    repeat (5) step();
    checks++;
    if (gate_open !== 1'b0) begin
      errors++; $display("FAIL held_req_reopen got %b want 0", gate_open);
    end
    gate_req = 1'b0;
    step();
  endtask

  task automatic test_pass();
    int bad = 0;
    gate_req = 1'b1;
    step();
    checks++;
    if (gate_open !== 1'b1 || alarm !== 1'b0) begin
      errors++; $display("FAIL pass_open got gate_open=%b alarm=%b want 1 0", gate_open, alarm);
    end
    gate_req = 1'b0;
    step();
    step();
    entry_pulse = 1'b1;
    step();
    entry_pulse = 1'b0;
    checks++;
    if (free_slots !== 4'd8 || seg7 !== 7'b0000000) begin
      errors++; $display("FAIL pass_count got free=%0d seg7=%b want 8 0000000", free_slots, seg7);
    end
    for (int i = 1; i <= int'(CLOSE_TICKS); i++) begin
      if (gate_open !== 1'b1 && bad == 0) bad = i;
      // A second car during PASS must not be counted.
      entry_pulse = (i == 3);
      step();
    end
    entry_pulse = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL pass_hold gate_open low at pass cycle %0d want high", bad);
    end
    checks++;
    if (gate_open !== 1'b0) begin
      errors++; $display("FAIL pass_close got %b want 0", gate_open);
    end
    checks++;
    if (free_slots !== 4'd8) begin
      errors++; $display("FAIL pass_second_car got free=%0d want 8", free_slots);
    end
  endtask

  task automatic test_full();
    repeat (8) admit_car();
    checks++;
    if (full !== 1'b1 || free_slots !== 4'd0 || seg7 !== 7'b1000000) begin
      errors++; $display("FAIL full_state got full=%b free=%0d seg7=%b want 1 0 1000000",
                         full, free_slots, seg7);
    end
    gate_req = 1'b1;
    step();
    gate_req = 1'b0;
    checks++;
    if (denied !== 1'b1 || gate_open !== 1'b0) begin
      errors++; $display("FAIL denied_pulse got denied=%b gate_open=%b want 1 0", denied, gate_open);
    end
    step();
    checks++;
    if (denied !== 1'b0 || gate_open !== 1'b0) begin
      errors++; $display("FAIL denied_end got denied=%b gate_open=%b want 0 0", denied, gate_open);
    end
    exit_pulse = 1'b1;
    step();
    exit_pulse = 1'b0;
    checks++;
    if (full !== 1'b0 || free_slots !== 4'd1 || seg7 !== 7'b1111001) begin
      errors++; $display("FAIL exit_from_full got full=%b free=%0d seg7=%b want 0 1 1111001",
                         full, free_slots, seg7);
    end
  endtask

  task automatic both_pulses_in_open();
    gate_req = 1'b1;
    step();
    gate_req = 1'b0;
    entry_pulse = 1'b1;
    exit_pulse = 1'b1;
    step();
    entry_pulse = 1'b0;
    exit_pulse = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    both_pulses_in_open();
    checks++;
    if (free_slots !== 4'd8) begin
      errors++; $display("FAIL both_at_zero got free=%0d want 8", free_slots);
    end
    repeat (CLOSE_TICKS) step();
    repeat (3) admit_car();
    both_pulses_in_open();
    checks++;
    if (free_slots !== 4'd5) begin
      errors++; $display("FAIL both_at_four got free=%0d want 5", free_slots);
    end
    repeat (CLOSE_TICKS) step();
  endtask

  task automatic test_edges();
    do_reset();
    exit_pulse = 1'b1;
    step();
    exit_pulse = 1'b0;
    checks++;
    if (free_slots !== 4'd9) begin
      errors++; $display("FAIL exit_at_zero got free=%0d want 9", free_slots);
    end
    entry_pulse = 1'b1;
    step();
    entry_pulse = 1'b0;
    step();
    checks++;
    if (free_slots !== 4'd9 || gate_open !== 1'b0) begin
      errors++; $display("FAIL entry_in_idle got free=%0d gate_open=%b want 9 0",
                         free_slots, gate_open);
    end
  endtask

  task automatic test_reset_mid_pass();
    repeat (4) admit_car();
    gate_req = 1'b1;
    step();
    gate_req = 1'b0;
    entry_pulse = 1'b1;
    step();
    entry_pulse = 1'b0;
    step();
    checks++;
    if (gate_open !== 1'b1 || free_slots !== 4'd4) begin
      errors++; $display("FAIL mid_pass_setup got gate_open=%b free=%0d want 1 4",
                         gate_open, free_slots);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (gate_open !== 1'b0 || free_slots !== 4'd9 || full !== 1'b0) begin
      errors++; $display("FAIL async_reset got gate_open=%b free=%0d full=%b want 0 9 0",
                         gate_open, free_slots, full);
    end
    step();
    reset = 1'b0;
    gate_req = 1'b1;
    step();
    gate_req = 1'b0;
    checks++;
    if (gate_open !== 1'b1) begin
      errors++; $display("FAIL reset_to_idle got gate_open=%b want 1", gate_open);
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_pass();
    test_full();
    test_simultaneous();
    test_edges();
    test_reset_mid_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
